// File: rtl/hello_scroll_led7_pkg.sv
// ============================================================================
// hello_scroll_led7_pkg : character codes, segment patterns and message ROM
// Revision 1.0
// ============================================================================
`default_nettype none

package hello_scroll_led7_pkg;

    localparam logic [2:0] CH_H     = 3'd0;
    localparam logic [2:0] CH_E     = 3'd1;
    localparam logic [2:0] CH_L     = 3'd2;
    localparam logic [2:0] CH_L2    = 3'd3;
    localparam logic [2:0] CH_O     = 3'd4;
    localparam logic [2:0] CH_BLANK = 3'd5;

    localparam logic [7:0] SEG_H   = 8'h89;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_L   = 8'hC7;
    localparam logic [7:0] SEG_O   = 8'hC0;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam int MSG_LEN = 8;

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Message "HELLO   ": slot k holds code k, trailing slots are blank.
    function automatic logic [2:0] msg_char(input logic [2:0] idx);
        logic [2:0] ch;
        ch = CH_BLANK;
        case (idx)
            3'd0:    ch = CH_H;
            3'd1:    ch = CH_E;
            3'd2:    ch = CH_L;
            3'd3:    ch = CH_L2;
            3'd4:    ch = CH_O;
            default: ch = CH_BLANK;
        endcase
        return ch;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hello_scroll_led7_seg_code_decode.sv
// ============================================================================
// seg_code_decode : 3-bit character code to active-low 7-seg pattern (DP off)
// Revision 1.0
// ============================================================================
`default_nettype none

module seg_code_decode
    import hello_scroll_led7_pkg::*;
(
    input  logic [2:0] code,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            CH_H:    seg = SEG_H;
            CH_E:    seg = SEG_E;
            CH_L:    seg = SEG_L;
            CH_L2:   seg = SEG_L;
            CH_O:    seg = SEG_O;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hello_scroll_led7.sv
// ============================================================================
// hello_scroll_led7 : scrolls "HELLO   " across HEX3..HEX0 with run/pause/step
// Revision 1.0
// ============================================================================
`default_nettype none

module hello_scroll_led7
    import hello_scroll_led7_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       KEY1,
    input  logic [1:0] SW,
    output logic [7:0] HEX3,
    output logic [7:0] HEX2,
    output logic [7:0] HEX1,
    output logic [7:0] HEX0,
    output logic [2:0] LEDR
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic          key_s1, key_s2, key_d;
    logic [1:0]    sw_s1, sw_s2;
    logic [PW-1:0] prescaler;
    state_t        state;
    logic [2:0]    pos;
    logic          step, tick, advance;
    logic [7:0]    seg_next [4];

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_d  <= 1'b1;
            sw_s1  <= 2'b00;
            sw_s2  <= 2'b00;
        end else begin
            key_s1 <= KEY1;
            key_s2 <= key_s1;
            key_d  <= key_s2;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    assign step    = key_d & ~key_s2;
    assign tick    = (state == ST_RUN) && (prescaler == PRESC_MAX);
    assign advance = (state == ST_RUN) ? tick : step;

    // Advance and state change share a cycle, so a tick or step that coincides
    // with a mode switch is still honoured by the mode it occurred in.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state     <= ST_PAUSE;
            prescaler <= '0;
            pos       <= 3'd0;
        end else begin
            case (state)
                ST_PAUSE: if (sw_s2[0]) state <= ST_RUN;
                ST_RUN: begin
                    prescaler <= tick ? '0 : prescaler + 1'b1;
                    if (!sw_s2[0]) state <= ST_PAUSE;
                end
                default: state <= ST_PAUSE;
            endcase
            if (advance) pos <= sw_s2[1] ? pos - 3'd1 : pos + 3'd1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_digit
        localparam logic [2:0] OFS = 3'(i);
        logic [2:0] idx;
        assign idx = pos + OFS;
        seg_code_decode u_dec (
            .code (msg_char(idx)),
            .seg  (seg_next[i])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            HEX3 <= SEG_H;
            HEX2 <= SEG_E;
            HEX1 <= SEG_L;
            HEX0 <= SEG_L;
            LEDR <= 3'd0;
        end else begin
            HEX3 <= seg_next[0];
            HEX2 <= seg_next[1];
            HEX1 <= seg_next[2];
            HEX0 <= seg_next[3];
            LEDR <= pos;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hello_scroll_led7.sv
// ============================================================================
// tb_hello_scroll_led7 : directed vector bench for hello_scroll_led7
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hello_scroll_led7;

    logic       clk;
    logic       key0, key1;
    logic [1:0] sw;
    logic [7:0] hex3, hex2, hex1, hex0;
    logic [2:0] ledr;

    int n_checks = 0;
    int n_fail   = 0;

    hello_scroll_led7 #(.TICK_DIV(4)) dut (
        .CLOCK_50 (clk),
        .KEY0     (key0),
        .KEY1     (key1),
        .SW       (sw),
        .HEX3     (hex3),
        .HEX2     (hex2),
        .HEX1     (hex1),
        .HEX0     (hex0),
        .LEDR     (ledr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected {HEX3,HEX2,HEX1,HEX0} for each scroll position.
    logic [31:0] exp_hex [8];

    typedef struct {
        logic [1:0]  sw;
        int          wait_n;
        logic [2:0]  led;
        logic [31:0] hex;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [2:0] e_led, input logic [31:0] e_hex);
        n_checks++;
        if (ledr !== e_led || {hex3, hex2, hex1, hex0} !== e_hex) begin
            n_fail++;
            $display("FAIL %s: got LEDR=%0d HEX=%h_%h_%h_%h, expected LEDR=%0d HEX=%h_%h_%h_%h",
                     name, ledr, hex3, hex2, hex1, hex0,
                     e_led, e_hex[31:24], e_hex[23:16], e_hex[15:8], e_hex[7:0]);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] sw_val);
        key0 = 1'b0;
        key1 = 1'b1;
        sw   = sw_val;
        cyc(2);
        key0 = 1'b1;
        cyc(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_hex[0] = 32'h89_86_C7_C7;
        exp_hex[1] = 32'h86_C7_C7_C0;
        exp_hex[2] = 32'hC7_C7_C0_FF;
        exp_hex[3] = 32'hC7_C0_FF_FF;
        exp_hex[4] = 32'hC0_FF_FF_FF;
        exp_hex[5] = 32'hFF_FF_FF_89;
        exp_hex[6] = 32'hFF_FF_89_86;
        exp_hex[7] = 32'hFF_89_86_C7;

        // Run left from reset (first step 8 cycles after SW change), wrap, then reverse.
        vecs[0] = '{2'b01, 7, 3'd0, 32'h89_86_C7_C7};
        vecs[1] = '{2'b01, 1, 3'd1, 32'h86_C7_C7_C0};
        vecs[2] = '{2'b01, 4, 3'd2, 32'hC7_C7_C0_FF};
        vecs[3] = '{2'b01, 4, 3'd3, 32'hC7_C0_FF_FF};
        vecs[4] = '{2'b01, 4, 3'd4, 32'hC0_FF_FF_FF};
        vecs[5] = '{2'b01, 4, 3'd5, 32'hFF_FF_FF_89};
        vecs[6] = '{2'b01, 4, 3'd6, 32'hFF_FF_89_86};
        vecs[7] = '{2'b01, 4, 3'd7, 32'hFF_89_86_C7};
        vecs[8] = '{2'b01, 4, 3'd0, 32'h89_86_C7_C7};
        vecs[9] = '{2'b11, 4, 3'd7, 32'hFF_89_86_C7};

        key0 = 1'b0;
        key1 = 1'b1;
        sw   = 2'b00;
        cyc(3);
        check("reset_hold", 3'd0, 32'h89_86_C7_C7);
        key0 = 1'b1;
        cyc(5);
        check("reset_release_stable", 3'd0, 32'h89_86_C7_C7);

        for (int i = 0; i < 10; i++) begin
            sw = vecs[i].sw;
            cyc(vecs[i].wait_n);
            check($sformatf("vec%0d", i), vecs[i].led, vecs[i].hex);
        end
        cyc(4);
        check("run_right_pos6", 3'd6, exp_hex[6]);

        // Pause + three KEY1 presses; each lands 4 cycles after the pin falls.
        do_reset(2'b00);
        for (int p = 0; p < 3; p++) begin
            key1 = 1'b0;
            cyc(3);
            check($sformatf("step%0d_before", p), 3'(p), exp_hex[p]);
            cyc(1);
            check($sformatf("step%0d_after", p), 3'(p + 1), exp_hex[p + 1]);
            cyc(6);
            check($sformatf("step%0d_held", p), 3'(p + 1), exp_hex[p + 1]);
            key1 = 1'b1;
            cyc(10);
        end
        check("step_final", 3'd3, 32'hC7_C0_FF_FF);

        // Pause while the prescaler sits at 3, then resume: tick comes immediately.
        do_reset(2'b00);
        sw = 2'b01;
        cyc(3);
        sw = 2'b00;
        cyc(20);
        check("pause_hold", 3'd0, exp_hex[0]);
        sw = 2'b01;
        cyc(4);
        check("resume_before_tick", 3'd0, exp_hex[0]);
        cyc(1);
        check("resume_tick", 3'd1, exp_hex[1]);
        cyc(1);
        key1 = 1'b0;
        cyc(3);
        check("run_tick_pos2", 3'd2, exp_hex[2]);
        cyc(1);
        check("run_step_ignored", 3'd2, exp_hex[2]);
        key1 = 1'b1;
        cyc(4);

        // Async reset mid-run at pos=5, prescaler=3.
        do_reset(2'b00);
        sw = 2'b01;
        cyc(26);
        check("pre_async_pos5", 3'd5, exp_hex[5]);
        #2 key0 = 1'b0;
        #1 check("async_reset", 3'd0, 32'h89_86_C7_C7);
        @(negedge clk);
        key0 = 1'b1;
        cyc(7);
        check("after_reset_wait", 3'd0, exp_hex[0]);
        cyc(1);
        check("after_reset_tick", 3'd1, exp_hex[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
